// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults, clear-FSM state type and init-value helper for the register file
package regfile_pkg;

    localparam int          DEF_XLEN    = 32;
    localparam int          DEF_NREG    = 32;
    localparam logic [31:0] DEF_SP_INIT = 32'h0000_3FFC;
    localparam logic [31:0] DEF_GP_INIT = 32'h0000_1800;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_e;

    // Architectural reset value of register idx: x2 = stack pointer, x3 = global pointer, rest zero.
    function automatic logic [63:0] init_val(input logic [31:0] idx,
                                             input logic [63:0] sp_init,
                                             input logic [63:0] gp_init);
        case (idx)
            32'd2:   return sp_init;
            32'd3:   return gp_init;
            default: return 64'd0;
        endcase
    endfunction

endpackage

// File: rtl/regfile_clr_fsm.sv
// rtl/regfile_clr_fsm.sv - multi-cycle clear sequencer walking x1..x(NREG-1)
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter int NREG = DEF_NREG,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req,
    output logic          ready,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr,
    output logic          clr_done
);

    clr_state_e    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          ready_q, ready_d;

    // State, counter and ready registers; reset lands in IDLE with the file available.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // Next-state logic: x0 is skipped, so the walk starts at 1 and ends at NREG-1.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ready_d  = ready_q;
        clr_we   = 1'b0;
        clr_addr = cnt_q;
        clr_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = AW'(1);
                    ready_d = 1'b0;
                end
            end
            CLEAR: begin
                clr_we = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == AW'(NREG - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                clr_done = 1'b1;
                ready_d  = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    assign ready = ready_q;

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with write bypass, pending scoreboard and clear engine
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int               XLEN    = DEF_XLEN,
    parameter int               NREG    = DEF_NREG,
    parameter int               AW      = $clog2(NREG),
    parameter logic [XLEN-1:0]  SP_INIT = XLEN'(DEF_SP_INIT),
    parameter logic [XLEN-1:0]  GP_INIT = XLEN'(DEF_GP_INIT)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic [AW-1:0]   rd_addr1,
    input  logic [AW-1:0]   rd_addr2,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            sb_set,
    input  logic [AW-1:0]   sb_addr,
    input  logic            flush,
    input  logic            clr_req,
    output logic            ready
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] pend_q, pend_d;

    logic          clr_we;
    logic [AW-1:0] clr_addr;
    logic          clr_done;
    logic          wr_act;
    logic [XLEN-1:0] clr_val;

    regfile_clr_fsm #(
        .NREG (NREG),
        .AW   (AW)
    ) u_clr_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .ready    (ready),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .clr_done (clr_done)
    );

    // A write-back only takes effect while the file is available and never targets x0.
    assign wr_act  = ready && wr_en && (wr_addr != '0);
    assign clr_val = XLEN'(init_val(32'(clr_addr), 64'(SP_INIT), 64'(GP_INIT)));

    // Storage next-state: the clear engine owns the write path while it runs.
    always_comb begin
        regs_d = regs_q;
        if (clr_we) begin
            regs_d[clr_addr] = clr_val;
        end else if (wr_act) begin
            regs_d[wr_addr] = wr_data;
        end
        regs_d[0] = '0;
    end

    // Storage registers, reset to architectural init values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= XLEN'(init_val(32'(i), 64'(SP_INIT), 64'(GP_INIT)));
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Scoreboard next-state: issue set beats write-back clear, flush beats both.
    always_comb begin
        pend_d = pend_q;
        if (clr_done) begin
            pend_d = '0;
        end else if (ready) begin
            if (flush) begin
                pend_d = '0;
            end else begin
                if (wr_act) begin
                    pend_d[wr_addr] = 1'b0;
                end
                if (sb_set) begin
                    pend_d[sb_addr] = 1'b1;
                end
            end
        end
        pend_d[0] = 1'b0;
    end

    // Pending bit registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Read ports: x0 reads zero, a same-cycle write-back is forwarded and also resolves the hazard.
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        rs1_busy = 1'b0;
        rs2_busy = 1'b0;
        if (rd_addr1 != '0) begin
            rs1_data = (wr_act && wr_addr == rd_addr1) ? wr_data : regs_q[rd_addr1];
            rs1_busy = pend_q[rd_addr1] && !(wr_act && wr_addr == rd_addr1);
        end
        if (rd_addr2 != '0) begin
            rs2_data = (wr_act && wr_addr == rd_addr2) ? wr_data : regs_q[rd_addr2];
            rs2_busy = pend_q[rd_addr2] && !(wr_act && wr_addr == rd_addr2);
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - randomized self-checking bench for regfile_sb against a behavioural model
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam logic [31:0] SP_V = 32'h0000_3FFC;
    localparam logic [31:0] GP_V = 32'h0000_1800;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            wr_en = 1'b0;
    logic [AW-1:0]   wr_addr = '0;
    logic [XLEN-1:0] wr_data = '0;
    logic [AW-1:0]   rd_addr1 = '0;
    logic [AW-1:0]   rd_addr2 = '0;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic            rs1_busy, rs2_busy;
    logic            sb_set = 1'b0;
    logic [AW-1:0]   sb_addr = '0;
    logic            flush = 1'b0;
    logic            clr_req = 1'b0;
    logic            ready;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [31:0] m_regs [NREG];
    bit          m_pend [NREG];
    int          m_busy;
    int          m_step;

    regfile_sb dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .sb_set   (sb_set),
        .sb_addr  (sb_addr),
        .flush    (flush),
        .clr_req  (clr_req),
        .ready    (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] arch_init(input int idx);
        if (idx == 2) return SP_V;
        if (idx == 3) return GP_V;
        return 32'd0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_regs[i] = arch_init(i);
            m_pend[i] = 1'b0;
        end
        m_busy = 0;
        m_step = 0;
    endtask

    function automatic logic [31:0] exp_rs(input int a);
        if (a == 0) return 32'd0;
        if (m_busy == 0 && wr_en && int'(wr_addr) == a) return wr_data;
        return m_regs[a];
    endfunction

    function automatic logic [31:0] exp_busy(input int a);
        if (a == 0) return 32'd0;
        if (m_busy == 0 && wr_en && int'(wr_addr) == a) return 32'd0;
        return {31'd0, m_pend[a]};
    endfunction

    task automatic compare_all();
        check("rs1_data", rs1_data, exp_rs(int'(rd_addr1)));
        check("rs2_data", rs2_data, exp_rs(int'(rd_addr2)));
        check("rs1_busy", {31'd0, rs1_busy}, exp_busy(int'(rd_addr1)));
        check("rs2_busy", {31'd0, rs2_busy}, exp_busy(int'(rd_addr2)));
        check("ready", {31'd0, ready}, {31'd0, m_busy == 0});
    endtask

    // Apply one clock edge to the model using the inputs currently driven.
    task automatic model_edge();
        if (m_busy == 0) begin
            if (wr_en && wr_addr != 0) m_regs[wr_addr] = wr_data;
            if (flush) begin
                for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
            end else begin
                if (wr_en) m_pend[wr_addr] = 1'b0;
                if (sb_set && sb_addr != 0) m_pend[sb_addr] = 1'b1;
            end
            if (clr_req) begin
                m_busy = NREG;
                m_step = 1;
            end
        end else begin
            if (m_step < NREG) m_regs[m_step] = arch_init(m_step);
            m_step++;
            m_busy--;
            if (m_busy == 0) begin
                for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        compare_all();
        tick();
    endtask

    task automatic idle_inputs();
        wr_en = 0; sb_set = 0; flush = 0; clr_req = 0;
    endtask

    task automatic readback_all();
        idle_inputs();
        for (int i = 0; i < NREG; i++) begin
            rd_addr1 = AW'(i);
            rd_addr2 = AW'(NREG - 1 - i);
            step();
        end
    endtask

    task automatic write_reg(input int a, input logic [31:0] d);
        idle_inputs();
        wr_en = 1; wr_addr = AW'(a); wr_data = d;
        step();
        wr_en = 0;
    endtask

    initial begin
        model_reset();
        #12;
        // 1: reset values
        rd_addr1 = 5'd2; rd_addr2 = 5'd3;
        @(negedge clk);
        check("rst_x2", rs1_data, SP_V);
        check("rst_x3", rs2_data, GP_V);
        check("rst_ready", {31'd0, ready}, 32'd1);
        rst_n = 1'b1;
        rd_addr1 = 5'd5;
        #1;
        check("rst_x5", rs1_data, 32'd0);
        check("rst_busy", {31'd0, rs1_busy | rs2_busy}, 32'd0);
        tick();

        // 2: x0 write ignored, bypass on x7
        wr_en = 1; wr_addr = 0; wr_data = 32'hDEADBEEF; rd_addr1 = 0; rd_addr2 = 0;
        @(negedge clk);
        check("x0_read", rs1_data, 32'd0);
        compare_all();
        tick();
        wr_addr = 7; rd_addr1 = 7;
        @(negedge clk);
        check("bypass_x7", rs1_data, 32'hDEADBEEF);
        compare_all();
        tick();
        idle_inputs();
        rd_addr1 = 0;
        step();

        // 3: scoreboard on x9
        sb_set = 1; sb_addr = 9; rd_addr2 = 9;
        step();
        sb_set = 0;
        @(negedge clk);
        check("sb_busy9", {31'd0, rs2_busy}, 32'd1);
        wr_en = 1; wr_addr = 9; wr_data = 32'h99;
        #1;
        check("sb_wr_hides", {31'd0, rs2_busy}, 32'd0);
        tick();
        sb_set = 1; sb_addr = 9; wr_en = 1; wr_addr = 9;
        step();
        idle_inputs();
        @(negedge clk);
        check("sb_set_wins", {31'd0, rs2_busy}, 32'd1);
        tick();

        // 6: flush beats sb_set
        for (int i = 1; i <= 4; i++) begin
            sb_set = 1; sb_addr = AW'(i);
            step();
        end
        sb_set = 1; sb_addr = 6; flush = 1;
        step();
        idle_inputs();
        rd_addr1 = 6; rd_addr2 = 3;
        @(negedge clk);
        check("flush_x6", {31'd0, rs1_busy}, 32'd0);
        check("flush_x3", {31'd0, rs2_busy}, 32'd0);
        tick();
        readback_all();

        // 4: clear sequence
        write_reg(5, 32'h55);
        write_reg(2, 32'h1);
        sb_set = 1; sb_addr = 12;
        step();
        idle_inputs();
        clr_req = 1;
        step();
        clr_req = 0;
        for (int c = 0; c < NREG; c++) begin
            wr_en = 1; wr_addr = AW'($urandom_range(1, NREG - 1)); wr_data = $urandom;
            sb_set = 1; sb_addr = 5'd20;
            rd_addr1 = wr_addr; rd_addr2 = 5'd12;
            @(negedge clk);
            check("clr_ready_low", {31'd0, ready}, 32'd0);
            compare_all();
            tick();
        end
        idle_inputs();
        rd_addr1 = 5; rd_addr2 = 2;
        @(negedge clk);
        check("clr_ready_back", {31'd0, ready}, 32'd1);
        check("clr_x5", rs1_data, 32'd0);
        check("clr_x2", rs2_data, SP_V);
        rd_addr1 = 12; rd_addr2 = 20;
        #1;
        check("clr_pend12", {31'd0, rs1_busy}, 32'd0);
        check("clr_pend20", {31'd0, rs2_busy}, 32'd0);
        tick();
        readback_all();

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            bit narrow;
            narrow = ($urandom_range(0, 1) == 1);
            wr_en    = ($urandom_range(0, 1) == 1);
            wr_addr  = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
            wr_data  = $urandom;
            rd_addr1 = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
            rd_addr2 = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
            sb_set   = ($urandom_range(0, 1) == 1);
            sb_addr  = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
            flush    = ($urandom_range(0, 15) == 0);
            clr_req  = ($urandom_range(0, 63) == 0);
            step();
        end
        readback_all();

        // 5: reset in the middle of a clear
        for (int i = 1; i < NREG; i++) write_reg(i, $urandom | 32'h1);
        clr_req = 1;
        step();
        clr_req = 0;
        for (int c = 0; c < 10; c++) step();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midclr_ready", {31'd0, ready}, 32'd1);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        readback_all();
        for (int c = 0; c < 4; c++) step();
        check("post_rst_ready", {31'd0, ready}, 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
